cdc_handshake_tx: RTL and testbench

Source side of a four-phase req/ack clock-domain-crossing handshake. Accepts a WIDTH-bit word from local logic with a valid/ready handshake and presents it on a register-driven bus. It then raises `req_out`, waits for the asynchronous `ack_in` (synchronised internally through SYNC_STAGES flops), and completes the return-to-zero phase. It sits at the edge of the `clk` domain, facing a receiver in another clock domain or unclocked logic.

---
 rtl/cdc_handshake_tx.sv | 139 +++++++++++++
 tb/tb_cdc_handshake_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack CDC handshake; CDC_TX_TIMEOUT_EN adds a REQ-phase timeout abort.
// Latency: loopback accept-to-done is 2*(SYNC_STAGES+1) cycles; in_ready is low for the whole handshake.
// Backpressure: one word in flight, nothing queued; in_valid is ignored until the return-to-zero completes.
module cdc_handshake_tx #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             req_out,
  input  logic             ack_in,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, REQ, ACK_LOW} state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       data_q;
  logic                   req_q;
  logic                   done_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  // ack_in is asynchronous to clk; only the last synchroniser flop is ever observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

`ifdef CDC_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             aborted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q    <= in_data;
            req_q     <= 1'b1;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            state_q   <= REQ;
          end
        end
        REQ: begin
          // An acknowledge arriving on the limit cycle takes priority over the abort.
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= ACK_LOW;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt_q     <= cnt_q + CNT_W'(1);
            req_q     <= 1'b0;
            err_q     <= 1'b1;
            aborted_q <= 1'b1;
            state_q   <= ACK_LOW;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ACK_LOW: begin
          if (!ack_s) begin
            done_q  <= !aborted_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign err = err_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= ACK_LOW;
          end
        end
        ACK_LOW: begin
          if (!ack_s) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign err = 1'b0;
`endif

  assign in_ready = (state_q == IDLE);
  assign data_out = data_q;
  assign req_out  = req_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx (WIDTH=8, SYNC_STAGES=2, TIMEOUT_CYCLES=8).
// Timeout scenarios are exercised when CDC_TX_TIMEOUT_EN is defined, the no-timeout scenario otherwise.
module tb_cdc_handshake_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_out;
  logic       req_out;
  logic       done;
  logic       err;
  logic       loop_en;
  logic       ack_man;
  wire        ack_in = loop_en ? req_out : ack_man;

  int n_checks = 0;
  int n_errors = 0;

  cdc_handshake_tx #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_out(data_out),
    .req_out(req_out),
    .ack_in(ack_in),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a word and let the next edge accept it; returns just after that edge (E0).
  task automatic send(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad_rdy, bad_dat, bad_req, bad_err;
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    loop_en  = 1'b0;
    ack_man  = 1'b0;

    // Reset and idle
    ticks(3);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_req_out", {31'd0, req_out}, 32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'h00);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    tick();

    // Loopback single transfer of 0xA5
    loop_en = 1'b1;
    send(8'hA5);
    check("lb_e0_data", {24'd0, data_out}, 32'hA5);
    check("lb_e0_req", {31'd0, req_out}, 32'd1);
    check("lb_e0_rdy", {31'd0, in_ready}, 32'd0);
    ticks(2);
    check("lb_e2_req", {31'd0, req_out}, 32'd1);
    tick();
    check("lb_e3_req", {31'd0, req_out}, 32'd0);
    ticks(2);
    check("lb_e5_done", {31'd0, done}, 32'd0);
    tick();
    check("lb_e6_done", {31'd0, done}, 32'd1);
    check("lb_e6_rdy", {31'd0, in_ready}, 32'd1);
    check("lb_e6_data", {24'd0, data_out}, 32'hA5);
    tick();
    check("lb_e7_done", {31'd0, done}, 32'd0);

    // Slow receiver with 0x3C offered throughout
    loop_en = 1'b0;
    ack_man = 1'b0;
    send(8'hA5);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    bad_rdy = 1'b0;
    bad_dat = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (in_ready !== 1'b0) bad_rdy = 1'b1;
      if (data_out !== 8'hA5) bad_dat = 1'b1;
    end
    ack_man = 1'b1;
    ticks(2);
    check("slow_req_hold", {31'd0, req_out}, 32'd1);
    tick();
    check("slow_req_fall", {31'd0, req_out}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0) bad_rdy = 1'b1;
      if (data_out !== 8'hA5) bad_dat = 1'b1;
      if (i < 4) tick();
    end
    ack_man = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (in_ready !== 1'b0) bad_rdy = 1'b1;
      if (data_out !== 8'hA5) bad_dat = 1'b1;
    end
    check("slow_no_early_accept", {31'd0, bad_rdy}, 32'd0);
    check("slow_data_hold", {31'd0, bad_dat}, 32'd0);
    tick();
    check("slow_done", {31'd0, done}, 32'd1);
    check("slow_done_data", {24'd0, data_out}, 32'hA5);
    tick();
    in_valid = 1'b0;
    check("slow_accept_3c", {24'd0, data_out}, 32'h3C);
    check("slow_req_3c", {31'd0, req_out}, 32'd1);
    loop_en = 1'b1;
    wait_done("slow_3c_done", 20);
    tick();

    // Asynchronous reset while in REQ
    loop_en = 1'b0;
    ack_man = 1'b0;
    send(8'h77);
    ticks(2);
    check("mid_req_before", {31'd0, req_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, req_out}, 32'd0);
    check("mid_rst_data", {24'd0, data_out}, 32'h00);
    ticks(2);
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_rel_rdy", {31'd0, in_ready}, 32'd1);
    loop_en = 1'b1;
    tick();
    send(8'h11);
    check("mid_11_data", {24'd0, data_out}, 32'h11);
    ticks(5);
    check("mid_11_e5", {31'd0, done}, 32'd0);
    tick();
    check("mid_11_done", {31'd0, done}, 32'd1);
    tick();

`ifdef CDC_TX_TIMEOUT_EN
    // Timeout with ack_in stuck low
    loop_en = 1'b0;
    ack_man = 1'b0;
    send(8'h42);
    ticks(7);
    check("to_e7_req", {31'd0, req_out}, 32'd1);
    check("to_e7_err", {31'd0, err}, 32'd0);
    tick();
    check("to_e8_req", {31'd0, req_out}, 32'd0);
    check("to_e8_err", {31'd0, err}, 32'd1);
    check("to_e8_done", {31'd0, done}, 32'd0);
    tick();
    check("to_e9_err", {31'd0, err}, 32'd0);
    check("to_e9_done", {31'd0, done}, 32'd0);
    check("to_e9_rdy", {31'd0, in_ready}, 32'd1);
    tick();

    // ack_s rising exactly on the limit cycle
    send(8'h99);
    ticks(5);
    ack_man = 1'b1;
    ticks(2);
    check("lim_e7_req", {31'd0, req_out}, 32'd1);
    tick();
    check("lim_e8_req", {31'd0, req_out}, 32'd0);
    check("lim_e8_err", {31'd0, err}, 32'd0);
    ack_man = 1'b0;
    bad_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (err !== 1'b0) bad_err = 1'b1;
    end
    check("lim_done", {31'd0, done}, 32'd1);
    check("lim_no_err", {31'd0, bad_err}, 32'd0);
    tick();
`else
    // Without the timeout, REQ waits indefinitely
    loop_en = 1'b0;
    ack_man = 1'b0;
    send(8'h5A);
    bad_req = 1'b0;
    bad_err = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (req_out !== 1'b1) bad_req = 1'b1;
      if (err !== 1'b0) bad_err = 1'b1;
    end
    check("noto_req_held", {31'd0, bad_req}, 32'd0);
    check("noto_err_zero", {31'd0, bad_err}, 32'd0);
    loop_en = 1'b1;
    wait_done("noto_release_done", 20);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
